// File: rtl/pwm_timer_ctrl_if.sv
// Configuration and status bundle between a PWM timer controller and its host/generator.
// The master drives the cfg_* requests; the slave (the timer) drives the active values and status.
interface pwm_timer_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 8
);
  logic             cfg_en;
  logic             cfg_oneshot;
  logic [PSC_W-1:0] cfg_prescale;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_compare1;
  logic [CNT_W-1:0] cfg_compare2;
  logic [1:0]       cfg_functions;
  logic             cfg_update;
  logic             cfg_restart;

  logic [CNT_W-1:0] count_val;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] compare1;
  logic [CNT_W-1:0] compare2;
  logic [1:0]       functions;
  logic [PSC_W-1:0] prescale_act;
  logic             pwm_en;
  logic             period_irq;
  logic             update_pending;
  logic             busy;

  modport master (
    output cfg_en, cfg_oneshot, cfg_prescale, cfg_period, cfg_compare1, cfg_compare2,
           cfg_functions, cfg_update, cfg_restart,
    input  count_val, period, compare1, compare2, functions, prescale_act, pwm_en,
           period_irq, update_pending, busy
  );

  modport slave (
    input  cfg_en, cfg_oneshot, cfg_prescale, cfg_period, cfg_compare1, cfg_compare2,
           cfg_functions, cfg_update, cfg_restart,
    output count_val, period, compare1, compare2, functions, prescale_act, pwm_en,
           period_irq, update_pending, busy
  );
endinterface

// File: rtl/pwm_timer_ctrl.sv
// Timebase (prescaler + up-counter) and shadow-register sequencer for one PWM channel.
// Requested settings are committed to the active registers only at start, restart or period wrap.
module pwm_timer_ctrl #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 8
) (
  input logic              clk,
  input logic              rst,
  pwm_timer_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] per_q, per_d, cmp1_q, cmp1_d, cmp2_q, cmp2_d;
  logic [1:0]       func_q, func_d;
  logic [PSC_W-1:0] psc_act_q, psc_act_d;

  logic             tick, wrap, commit, irq;
  logic [CNT_W:0]   cnt_inc;

  // 17-bit compare so that period 0 and period 1 both wrap on every tick
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign tick    = (psc_q == psc_act_q);
  assign wrap    = tick && (cnt_inc >= {1'b0, per_q});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    psc_d   = psc_q;
    pend_d  = pend_q;
    commit  = 1'b0;
    irq     = 1'b0;
    if (!bus.cfg_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      psc_d   = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          commit  = 1'b1;
          state_d = ST_RUN;
          cnt_d   = '0;
          psc_d   = '0;
        end
        ST_RUN: begin
          if (bus.cfg_restart) begin
            commit = 1'b1;
            cnt_d  = '0;
            psc_d  = '0;
          end else begin
            if (bus.cfg_update) pend_d = 1'b1;
            psc_d = tick ? '0 : psc_q + 1'b1;
            if (wrap) begin
              cnt_d = '0;
              irq   = 1'b1;
              // an update arriving on the wrap cycle itself commits right here
              commit = pend_d;
              if (bus.cfg_oneshot) state_d = ST_DONE;
            end else if (tick) begin
              cnt_d = cnt_inc[CNT_W-1:0];
            end
          end
        end
        ST_DONE: begin
          cnt_d = '0;
          psc_d = '0;
          if (bus.cfg_restart) begin
            commit  = 1'b1;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (commit) pend_d = 1'b0;
  end

  always_comb begin
    per_d     = per_q;
    cmp1_d    = cmp1_q;
    cmp2_d    = cmp2_q;
    func_d    = func_q;
    psc_act_d = psc_act_q;
    if (commit) begin
      per_d     = bus.cfg_period;
      cmp1_d    = bus.cfg_compare1;
      cmp2_d    = bus.cfg_compare2;
      func_d    = bus.cfg_functions;
      psc_act_d = bus.cfg_prescale;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      psc_q     <= '0;
      pend_q    <= 1'b0;
      per_q     <= '0;
      cmp1_q    <= '0;
      cmp2_q    <= '0;
      func_q    <= '0;
      psc_act_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      psc_q     <= psc_d;
      pend_q    <= pend_d;
      per_q     <= per_d;
      cmp1_q    <= cmp1_d;
      cmp2_q    <= cmp2_d;
      func_q    <= func_d;
      psc_act_q <= psc_act_d;
    end
  end

  assign bus.count_val      = cnt_q;
  assign bus.period         = per_q;
  assign bus.compare1       = cmp1_q;
  assign bus.compare2       = cmp2_q;
  assign bus.functions      = func_q;
  assign bus.prescale_act   = psc_act_q;
  assign bus.pwm_en         = (state_q == ST_RUN);
  assign bus.busy           = (state_q == ST_RUN);
  assign bus.period_irq     = irq;
  assign bus.update_pending = pend_q;

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Self-checking bench for pwm_timer_ctrl: directed scenarios then random traffic,
// every output compared each cycle against a behavioural model.
module tb_pwm_timer_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_timer_ctrl_if bus ();
  pwm_timer_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // model: running/done flags, counter, prescaler, active settings, pending flag
  bit m_run, m_done, m_pend;
  int m_cnt, m_psc, m_per, m_c1, m_c2, m_fn, m_pa;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_run = 0; m_done = 0; m_pend = 0;
    m_cnt = 0; m_psc = 0; m_per = 0; m_c1 = 0; m_c2 = 0; m_fn = 0; m_pa = 0;
  endfunction

  function automatic void m_commit();
    m_per = bus.cfg_period; m_c1 = bus.cfg_compare1; m_c2 = bus.cfg_compare2;
    m_fn = bus.cfg_functions; m_pa = bus.cfg_prescale; m_pend = 0;
  endfunction

  function automatic bit m_irq();
    return m_run && bus.cfg_en && !bus.cfg_restart && (m_psc == m_pa) && (m_cnt + 1 >= m_per);
  endfunction

  function automatic void m_advance();
    bit tick, wrp;
    if (!bus.cfg_en) begin
      m_run = 0; m_done = 0; m_cnt = 0; m_psc = 0; m_pend = 0;
    end else if (!m_run && !m_done) begin
      m_commit(); m_run = 1; m_cnt = 0; m_psc = 0;
    end else if (m_done) begin
      if (bus.cfg_restart) begin m_commit(); m_run = 1; m_done = 0; end
    end else if (bus.cfg_restart) begin
      m_commit(); m_cnt = 0; m_psc = 0;
    end else begin
      tick = (m_psc == m_pa);
      wrp  = tick && (m_cnt + 1 >= m_per);
      if (bus.cfg_update) m_pend = 1;
      m_psc = tick ? 0 : m_psc + 1;
      if (wrp) begin
        m_cnt = 0;
        if (m_pend) m_commit();
        if (bus.cfg_oneshot) begin m_run = 0; m_done = 1; end
      end else if (tick) m_cnt++;
    end
  endfunction

  task automatic check_all();
    chk("count_val", bus.count_val, m_cnt);
    chk("period", bus.period, m_per);
    chk("compare1", bus.compare1, m_c1);
    chk("compare2", bus.compare2, m_c2);
    chk("functions", bus.functions, m_fn);
    chk("prescale_act", bus.prescale_act, m_pa);
    chk("pwm_en", bus.pwm_en, m_run);
    chk("busy", bus.busy, m_run);
    chk("update_pending", bus.update_pending, m_pend);
    chk("period_irq", bus.period_irq, m_irq());
  endtask

  // inputs are set by the caller after the previous posedge; sample on negedge, model on posedge
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    m_advance();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_update();
    bus.cfg_update = 1'b1; step(); bus.cfg_update = 1'b0;
  endtask

  task automatic pulse_restart();
    bus.cfg_restart = 1'b1; step(); bus.cfg_restart = 1'b0;
  endtask

  task automatic set_cfg(input int per, input int c1, input int c2, input int fn, input int psc);
    bus.cfg_period    = 16'(per);
    bus.cfg_compare1  = 16'(c1);
    bus.cfg_compare2  = 16'(c2);
    bus.cfg_functions = 2'(fn);
    bus.cfg_prescale  = 8'(psc);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 200 && m_cnt != target; i++) step();
    chk("reach_count", bus.count_val, target);
  endtask

  task automatic stop_timer();
    bus.cfg_en = 1'b0; step();
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_en = 0; bus.cfg_oneshot = 0; bus.cfg_update = 0; bus.cfg_restart = 0;
    set_cfg(0, 0, 0, 0, 0);
    m_reset();
    #12;
    check_all();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    steps(2);

    // basic run, prescale 0 period 4
    set_cfg(4, 1, 2, 1, 0); bus.cfg_en = 1; steps(14);
    stop_timer();

    // prescale 2, period 3
    set_cfg(3, 1, 2, 2, 2); bus.cfg_en = 1; steps(30);
    stop_timer();

    // shadowed compare1 update at count 4
    set_cfg(10, 3, 5, 0, 0); bus.cfg_en = 1; step();
    run_to(4);
    bus.cfg_compare1 = 16'd7; pulse_update();
    chk("c1_held", bus.compare1, 3);
    chk("pend_set", bus.update_pending, 1);
    steps(8);
    chk("c1_new", bus.compare1, 7);
    chk("pend_clr", bus.update_pending, 0);
    stop_timer();

    // one-shot then restart
    set_cfg(5, 2, 3, 3, 0); bus.cfg_oneshot = 1; bus.cfg_en = 1; steps(10);
    chk("oneshot_done_pwm", bus.pwm_en, 0);
    set_cfg(6, 1, 1, 0, 1); pulse_restart(); steps(20);
    bus.cfg_oneshot = 0; stop_timer();

    // restart mid-period and on a wrap cycle
    set_cfg(10, 4, 6, 1, 0); bus.cfg_en = 1; step();
    run_to(6);
    set_cfg(8, 2, 7, 2, 0); pulse_restart();
    chk("restart_count", bus.count_val, 0);
    chk("restart_period", bus.period, 8);
    run_to(7);
    pulse_restart(); steps(4);
    // update coinciding with a wrap
    run_to(7);
    set_cfg(5, 1, 2, 3, 0); pulse_update();
    chk("wrap_update_per", bus.period, 5);
    steps(4);

    // period 0 and period 1
    set_cfg(0, 0, 0, 0, 0); pulse_restart(); steps(6);
    set_cfg(1, 0, 0, 0, 1); pulse_update(); steps(8);
    stop_timer();

    // asynchronous reset at count 5
    set_cfg(10, 3, 4, 1, 0); bus.cfg_en = 1; step();
    run_to(5);
    #2 rst = 1'b1;
    #1 m_reset();
    check_all();
    bus.cfg_en = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    steps(3);

    // random traffic
    bus.cfg_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)
        set_cfg($urandom_range(12), $urandom_range(65535), $urandom_range(65535),
                $urandom_range(3), $urandom_range(3));
      bus.cfg_update  = ($urandom_range(9) == 0);
      bus.cfg_restart = ($urandom_range(24) == 0);
      if ($urandom_range(59) == 0) bus.cfg_oneshot = ~bus.cfg_oneshot;
      if (bus.cfg_en) bus.cfg_en = ($urandom_range(79) != 0);
      else            bus.cfg_en = ($urandom_range(2) == 0);
      step();
    end
    bus.cfg_update = 0; bus.cfg_restart = 0;
    steps(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_timer_ctrl.md
Name: pwm_timer_ctrl

Overview:
- Timebase and configuration sequencer that drives one PWM generator channel.
- Owns the prescaler and the 16-bit up-counter that produce count_val.
- Holds shadow copies of period, compare1, compare2 and functions, and commits them to the generator only at period boundaries, so waveform changes are glitch-free.
- Supports continuous and one-shot operation, forced restart, and a per-period pulse for interrupt logic.

Parameters:
- CNT_W, 16, width of counter, period and compare values.
- PSC_W, 8, width of the prescaler setting.

Ports:
- clk  in  1  peripheral clock
- rst  in  1  asynchronous, active-high reset
- cfg_en  in  1  level; timer run enable
- cfg_oneshot  in  1  level; 1 = stop after one period
- cfg_prescale  in  PSC_W  counter advances every cfg_prescale+1 clocks
- cfg_period  in  CNT_W  requested period
- cfg_compare1  in  CNT_W  requested compare1
- cfg_compare2  in  CNT_W  requested compare2
- cfg_functions  in  2  requested alignment mode
- cfg_update  in  1  pulse; request shadow commit at next boundary
- cfg_restart  in  1  pulse; immediate counter restart with commit
- count_val  out  CNT_W  counter value to generator
- period  out  CNT_W  active period
- compare1  out  CNT_W  active compare1
- compare2  out  CNT_W  active compare2
- functions  out  2  active mode
- prescale_act  out  PSC_W  active prescale
- pwm_en  out  1  generator enable
- period_irq  out  1  one-clock pulse at each wrap
- update_pending  out  1  commit requested, not yet applied
- busy  out  1  state is RUN

Behaviour:
- Reset: state IDLE, prescaler 0. All outputs are 0.
- A commit copies all cfg_* data inputs (period, compare1, compare2, functions, prescale) into the active registers in a single cycle and clears update_pending.
- State IDLE:
  - count_val = 0, pwm_en = 0, prescaler held at 0.
  - When cfg_en = 1: commit, then go to RUN on the next clock.
  - pwm_en = 1 from the first RUN cycle.
- State RUN:
  - A tick occurs when prescaler == prescale_act. On a tick the prescaler returns to 0; otherwise it increments.
  - On a tick with count_val + 1 >= period (17-bit compare, so period 0 and period 1 both wrap every tick):
    - count_val <= 0 and period_irq = 1 for that one clock.
    - If update_pending = 1, commit.
    - If cfg_oneshot = 1, go to DONE.
  - On any other tick: count_val <= count_val + 1.
  - Between ticks count_val holds.
- State DONE:
  - pwm_en = 0, count_val = 0, shadows hold.
  - cfg_restart goes to RUN with a commit.
  - cfg_en = 0 goes to IDLE.
- cfg_en = 0 in RUN or DONE: next cycle go to IDLE, count_val = 0, prescaler = 0, pwm_en = 0, update_pending cleared. Active registers keep their values.
- cfg_update pulse:
  - In RUN, sets update_pending.
  - In IDLE or DONE, ignored, because every start commits.
- cfg_restart in RUN: count_val = 0, prescaler = 0, commit, no period_irq. State stays RUN.
- cfg_restart in IDLE: ignored.
- Simultaneous events:
  - cfg_update on the same cycle as a wrap tick: commit happens at that wrap using the current cfg_* values; update_pending reads 0 afterwards.
  - cfg_restart together with a wrap: restart wins; no irq and no DONE entry.
  - cfg_en = 0 overrides everything.
- Changes to cfg_* without cfg_update or cfg_restart never affect the active outputs in RUN.
- Asynchronous rst mid-run: all outputs 0 immediately, with no waiting for clk.

Test Plan:
- prescale = 0, period = 4, cfg_en = 1 -> count_val runs 0,1,2,3,0,…; period_irq high on each 3→0 cycle; pwm_en = 1 from the first RUN cycle.
- prescale = 2, period = 3 -> each count value held 3 clocks; period_irq every 9 clocks.
- Running with period = 10, compare1 = 3. Set cfg_compare1 = 7 and pulse cfg_update at count 4 -> compare1 stays 3 and update_pending = 1 until the 9→0 wrap, then compare1 = 7 and update_pending = 0.
- cfg_oneshot = 1, period = 5 -> one pass 0..4, one period_irq, then DONE with pwm_en = 0 and count 0. cfg_restart -> RUN again from count 0.
- cfg_restart pulse at count 6 (period 10) -> next count 0, no irq, new cfg values active. cfg_restart on a wrap cycle -> no irq.
- period = 0 and period = 1 -> count_val stays 0 with period_irq every tick. Assert rst at count 5 -> all outputs 0 asynchronously; after release the block is in IDLE.
